// File: rtl/branch_resolve_ctrl_if.sv
// branch_resolve_ctrl_if: redirect handshake to IF and predictor-update port of the EX branch resolver.
interface branch_resolve_ctrl_if #(parameter int XLEN = 32);
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            redirect_ready;
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic            upd_taken;
    logic [XLEN-1:0] upd_target;
    modport master (
        output redirect_valid, redirect_pc, upd_valid, upd_pc, upd_taken, upd_target,
        input  redirect_ready
    );
    modport slave (
        input  redirect_valid, redirect_pc, upd_valid, upd_pc, upd_taken, upd_target,
        output redirect_ready
    );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: resolves RV32I branches/jumps in EX, redirects IF on mispredict, updates predictor and counters.
module cmp #(parameter int XLEN = 32) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      funct3,
    output logic            br_en
);
    logic eq, lt, ltu;
    always_comb begin
        eq = a == b;
        lt = $signed(a) < $signed(b);
        ltu = a < b;
        br_en = funct3[2] ? ((funct3[1] ? ltu : lt) ^ funct3[0]) : (!funct3[1] && (eq ^ funct3[0]));
    end
endmodule

module branch_resolve_ctrl #(
    parameter int XLEN    = 32,
    parameter int COUNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ex_valid,
    input  logic                 ex_is_br,
    input  logic                 ex_is_jal,
    input  logic                 ex_is_jalr,
    input  logic [2:0]           ex_funct3,
    input  logic [XLEN-1:0]      ex_rs1,
    input  logic [XLEN-1:0]      ex_rs2,
    input  logic [XLEN-1:0]      ex_pc,
    input  logic [XLEN-1:0]      ex_imm,
    input  logic                 ex_pred_taken,
    input  logic [XLEN-1:0]      ex_pred_target,
    output logic                 kill_younger,
    output logic                 stall_ex,
    output logic [COUNT_W-1:0]   br_cnt,
    output logic [COUNT_W-1:0]   mispred_cnt,
    branch_resolve_ctrl_if.master bus
);
    typedef enum logic {IDLE, WAIT_ACK} state_t;
    state_t          state, state_next;
    logic            br_en, taken, resolve, mispredict;
    logic [XLEN-1:0] target, next_pc;

    cmp #(.XLEN(XLEN)) u_cmp (.a(ex_rs1), .b(ex_rs2), .funct3(ex_funct3), .br_en(br_en));

    // Conflicting control-flow flags resolve nothing, so they never disturb the pipeline.
    always_comb begin
        target = ex_is_jalr ? ((ex_rs1 + ex_imm) & ~XLEN'(1)) : ex_pc + ex_imm;
        taken = ex_is_br ? br_en : 1'b1;
        next_pc = taken ? target : ex_pc + XLEN'(4);
        resolve = ex_valid && $onehot({ex_is_br, ex_is_jal, ex_is_jalr}) && state == IDLE;
        mispredict = resolve && (taken != ex_pred_taken || (taken && target != ex_pred_target));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_next;
    end

    always_comb begin
        state_next = state == IDLE ? (mispredict ? WAIT_ACK : IDLE) : (bus.redirect_ready ? IDLE : WAIT_ACK);
    end

    always_comb begin
        kill_younger = mispredict;
        stall_ex = state == WAIT_ACK;
        bus.redirect_valid = state == WAIT_ACK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.redirect_pc <= '0;
            bus.upd_valid <= 1'b0;
            bus.upd_pc <= '0;
            bus.upd_taken <= 1'b0;
            bus.upd_target <= '0;
            br_cnt <= '0;
            mispred_cnt <= '0;
        end else begin
            bus.upd_valid <= resolve;
            if (mispredict) begin
                bus.redirect_pc <= next_pc;
                mispred_cnt <= mispred_cnt + COUNT_W'(1);
            end
            if (resolve) begin
                bus.upd_pc <= ex_pc;
                bus.upd_taken <= taken;
                bus.upd_target <= target;
                br_cnt <= br_cnt + COUNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb_branch_resolve_ctrl: directed checks of resolve, redirect handshake, async reset and counter wrap.
module tb_branch_resolve_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid, ex_is_br, ex_is_jal, ex_is_jalr, ex_pred_taken;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_rs1, ex_rs2, ex_pc, ex_imm, ex_pred_target;
    logic        kill_younger, stall_ex;
    logic [3:0]  br_cnt, mispred_cnt;
    int          passed = 0;
    int          failed = 0;
    int          total = 0;

    branch_resolve_ctrl_if #(.XLEN(32)) bus ();

    branch_resolve_ctrl #(.XLEN(32), .COUNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_is_br(ex_is_br), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
        .ex_funct3(ex_funct3), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .kill_younger(kill_younger), .stall_ex(stall_ex),
        .br_cnt(br_cnt), .mispred_cnt(mispred_cnt),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_ex(input logic v, input logic br, input logic jal, input logic jalr, input logic [2:0] f3,
                          input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] pc,
                          input logic [31:0] imm, input logic pt, input logic [31:0] ptgt);
        ex_valid = v; ex_is_br = br; ex_is_jal = jal; ex_is_jalr = jalr; ex_funct3 = f3;
        ex_rs1 = rs1; ex_rs2 = rs2; ex_pc = pc; ex_imm = imm; ex_pred_taken = pt; ex_pred_target = ptgt;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.redirect_ready = 1'b0;
        set_ex(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("rst_redirect_valid", {31'd0, bus.redirect_valid}, 0);
        chk("rst_upd_valid", {31'd0, bus.upd_valid}, 0);
        chk("rst_br_cnt", {28'd0, br_cnt}, 0);
        chk("rst_mispred_cnt", {28'd0, mispred_cnt}, 0);
        chk("rst_kill", {31'd0, kill_younger}, 0);
        chk("rst_stall", {31'd0, stall_ex}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        // BEQ taken, correctly predicted
        set_ex(1, 1, 0, 0, 3'b000, 5, 5, 32'h100, 32'h20, 1, 32'h120);
        chk("beq_kill", {31'd0, kill_younger}, 0);
        chk("beq_stall", {31'd0, stall_ex}, 0);
        tick();
        ex_valid = 0;
        chk("beq_upd_valid", {31'd0, bus.upd_valid}, 1);
        chk("beq_upd_taken", {31'd0, bus.upd_taken}, 1);
        chk("beq_upd_target", bus.upd_target, 32'h120);
        chk("beq_upd_pc", bus.upd_pc, 32'h100);
        chk("beq_br_cnt", {28'd0, br_cnt}, 1);
        chk("beq_mispred_cnt", {28'd0, mispred_cnt}, 0);
        chk("beq_redirect_valid", {31'd0, bus.redirect_valid}, 0);
        tick();
        chk("beq_upd_drop", {31'd0, bus.upd_valid}, 0);
        chk("beq_upd_hold", bus.upd_target, 32'h120);
        // BLT signed taken, predicted not-taken
        set_ex(1, 1, 0, 0, 3'b100, 32'hFFFF_FFFF, 1, 32'h200, 32'h40, 0, 0);
        chk("blt_kill", {31'd0, kill_younger}, 1);
        tick();
        ex_valid = 0;
        chk("blt_redirect_valid", {31'd0, bus.redirect_valid}, 1);
        chk("blt_redirect_pc", bus.redirect_pc, 32'h240);
        chk("blt_mispred_cnt", {28'd0, mispred_cnt}, 1);
        chk("blt_br_cnt", {28'd0, br_cnt}, 2);
        chk("blt_stall", {31'd0, stall_ex}, 1);
        bus.redirect_ready = 1;
        tick();
        bus.redirect_ready = 0;
        chk("blt_ack_valid", {31'd0, bus.redirect_valid}, 0);
        chk("blt_ack_stall", {31'd0, stall_ex}, 0);
        // BLTU same operands: not taken, prediction correct
        set_ex(1, 1, 0, 0, 3'b110, 32'hFFFF_FFFF, 1, 32'h200, 32'h40, 0, 0);
        chk("bltu_kill", {31'd0, kill_younger}, 0);
        tick();
        ex_valid = 0;
        chk("bltu_upd_taken", {31'd0, bus.upd_taken}, 0);
        chk("bltu_upd_target", bus.upd_target, 32'h240);
        chk("bltu_br_cnt", {28'd0, br_cnt}, 3);
        chk("bltu_mispred_cnt", {28'd0, mispred_cnt}, 1);
        chk("bltu_redirect_valid", {31'd0, bus.redirect_valid}, 0);
        // JALR target clears bit 0; redirect held through a slow ack
        set_ex(1, 0, 0, 1, 3'b000, 32'h1003, 0, 32'h300, 0, 1, 32'h1000);
        chk("jalr_kill", {31'd0, kill_younger}, 1);
        tick();
        chk("jalr_upd_valid", {31'd0, bus.upd_valid}, 1);
        chk("jalr_upd_target", bus.upd_target, 32'h1002);
        for (int i = 0; i < 3; i++) begin
            chk("jalr_wait_valid", {31'd0, bus.redirect_valid}, 1);
            chk("jalr_wait_pc", bus.redirect_pc, 32'h1002);
            chk("jalr_wait_stall", {31'd0, stall_ex}, 1);
            chk("jalr_wait_kill", {31'd0, kill_younger}, 0);
            set_ex(i != 1, 1, 0, 0, 3'b000, 9, 9, 32'h700, 32'h8, 0, 0);
            tick();
            chk("jalr_wait_upd", {31'd0, bus.upd_valid}, 0);
        end
        chk("jalr_ack_stall", {31'd0, stall_ex}, 1);
        chk("jalr_ack_valid", {31'd0, bus.redirect_valid}, 1);
        bus.redirect_ready = 1;
        tick();
        ex_valid = 0;
        bus.redirect_ready = 0;
        chk("jalr_done_valid", {31'd0, bus.redirect_valid}, 0);
        chk("jalr_done_stall", {31'd0, stall_ex}, 0);
        chk("jalr_br_cnt", {28'd0, br_cnt}, 4);
        chk("jalr_mispred_cnt", {28'd0, mispred_cnt}, 2);
        // BNE not taken at top of address space: fall-through wraps to 0
        set_ex(1, 1, 0, 0, 3'b001, 7, 7, 32'hFFFF_FFFC, 32'h8, 1, 32'h4);
        chk("bne_kill", {31'd0, kill_younger}, 1);
        tick();
        ex_valid = 0;
        chk("bne_redirect_pc", bus.redirect_pc, 32'h0);
        chk("bne_redirect_valid", {31'd0, bus.redirect_valid}, 1);
        chk("bne_br_cnt", {28'd0, br_cnt}, 5);
        chk("bne_mispred_cnt", {28'd0, mispred_cnt}, 3);
        // async reset mid-handshake
        #2 rst_n = 0;
        #1;
        chk("arst_redirect_valid", {31'd0, bus.redirect_valid}, 0);
        chk("arst_redirect_pc", bus.redirect_pc, 0);
        chk("arst_br_cnt", {28'd0, br_cnt}, 0);
        chk("arst_mispred_cnt", {28'd0, mispred_cnt}, 0);
        chk("arst_stall", {31'd0, stall_ex}, 0);
        @(posedge clk);
        #1 rst_n = 1;
        set_ex(1, 0, 1, 0, 3'b000, 0, 0, 32'h400, 32'h10, 1, 32'h414);
        chk("post_rst_kill", {31'd0, kill_younger}, 1);
        tick();
        ex_valid = 0;
        chk("post_rst_redirect_pc", bus.redirect_pc, 32'h410);
        chk("post_rst_br_cnt", {28'd0, br_cnt}, 1);
        chk("post_rst_mispred_cnt", {28'd0, mispred_cnt}, 1);
        bus.redirect_ready = 1;
        tick();
        chk("post_rst_ack", {31'd0, bus.redirect_valid}, 0);
        // multiple flags: not control flow, redirect_ready ignored while idle
        set_ex(1, 1, 1, 0, 3'b000, 1, 2, 32'h480, 32'h8, 1, 32'h0);
        chk("multi_kill", {31'd0, kill_younger}, 0);
        tick();
        ex_valid = 0;
        bus.redirect_ready = 0;
        chk("multi_upd_valid", {31'd0, bus.upd_valid}, 0);
        chk("multi_br_cnt", {28'd0, br_cnt}, 1);
        chk("multi_redirect_valid", {31'd0, bus.redirect_valid}, 0);
        // back-to-back correct resolves up to the counter ceiling, then wrap
        for (int i = 0; i < 14; i++) begin
            set_ex(1, 1, 0, 0, 3'b101, 3, 3, 32'h500 + 32'(4 * i), 32'h40, 1, 32'h540 + 32'(4 * i));
            tick();
            chk("b2b_upd_valid", {31'd0, bus.upd_valid}, 1);
            chk("b2b_upd_pc", bus.upd_pc, 32'h500 + 32'(4 * i));
        end
        ex_valid = 0;
        #1;
        chk("ceil_br_cnt", {28'd0, br_cnt}, 15);
        set_ex(1, 0, 1, 0, 3'b000, 0, 0, 32'h600, 32'h8, 1, 32'h608);
        chk("wrap_kill", {31'd0, kill_younger}, 0);
        tick();
        ex_valid = 0;
        chk("wrap_br_cnt", {28'd0, br_cnt}, 0);
        chk("wrap_mispred_cnt", {28'd0, mispred_cnt}, 1);
        chk("wrap_upd_target", bus.upd_target, 32'h608);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- EX-stage controller that sequences branch/jump resolution for the RV32I pipeline.
- Instantiates one cmp comparator and computes the actual outcome and target.
- Checks the outcome against the fetch-stage prediction. On a mispredict it squashes younger instructions, holds a redirect to IF under a valid/ready handshake, and stalls EX until fetch accepts.
- Also drives the predictor-update port and the branch/mispredict performance counters.

Parameters:
- XLEN, 32, datapath width.
- COUNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_valid  in  1  EX holds a valid instruction this cycle.
- ex_is_br  in  1  conditional branch.
- ex_is_jal  in  1  JAL.
- ex_is_jalr  in  1  JALR.
- ex_funct3  in  3  branch_funct3_t, fed to cmp.
- ex_rs1  in  XLEN  forwarded rs1 value.
- ex_rs2  in  XLEN  forwarded rs2 value.
- ex_pc  in  XLEN  instruction PC.
- ex_imm  in  XLEN  sign-extended immediate.
- ex_pred_taken  in  1  fetch predicted taken.
- ex_pred_target  in  XLEN  fetch predicted target.
- kill_younger  out  1  combinational; squash IF/ID registers at this clock edge.
- stall_ex  out  1  hold EX and the upstream stages.
- redirect_valid  out  1  redirect request to IF.
- redirect_pc  out  XLEN  redirect address.
- redirect_ready  in  1  IF accepts the redirect.
- upd_valid  out  1  predictor update strobe.
- upd_pc  out  XLEN  PC for the update.
- upd_taken  out  1  actual outcome for the update.
- upd_target  out  XLEN  actual target for the update.
- br_cnt  out  COUNT_W  number of resolved control-flow instructions.
- mispred_cnt  out  COUNT_W  number of mispredicts.

Behaviour:
- Reset: asynchronous, active-low; takes effect immediately, including mid-handshake.
  - State goes to IDLE.
  - redirect_valid, upd_valid, upd_taken = 0.
  - redirect_pc, upd_pc, upd_target = 0.
  - br_cnt, mispred_cnt = 0.
  - kill_younger and stall_ex are low whenever state is IDLE and there is no mispredict.
- Resolve: an instruction resolves when ex_valid and exactly one of ex_is_br/ex_is_jal/ex_is_jalr is set and state is IDLE.
  - If more than one of the three is set, it is treated as no control flow. This is an assertion target in verification.
- Actual outcome: taken = br_en from cmp(ex_rs1, ex_rs2, ex_funct3) for branches; taken = 1 for JAL/JALR.
- Actual target:
  - Branch/JAL: ex_pc + ex_imm, modulo 2^XLEN.
  - JALR: (ex_rs1 + ex_imm) with bit 0 cleared.
- Next PC: target if taken, else ex_pc + 4 (wraps at 2^XLEN).
- mispredict = (taken != ex_pred_taken) OR (taken AND target != ex_pred_target). The predicted target is ignored when actual is not-taken.
- Cycle N, resolve with mispredict (state IDLE):
  - kill_younger = 1, combinational, in cycle N.
  - On the edge: redirect_pc <= next PC, redirect_valid <= 1, state <= WAIT_ACK.
- WAIT_ACK:
  - stall_ex = 1.
  - redirect_valid and redirect_pc are held stable until redirect_ready.
  - On a cycle with redirect_ready: redirect_valid <= 0 and state <= IDLE. A new resolve is accepted in the following cycle at the earliest.
  - ex_valid is ignored in WAIT_ACK. No resolve, counter increment or update occurs.
  - redirect_ready is ignored while redirect_valid is 0.
- Correct prediction: no kill, no stall, no redirect. Throughput is one resolve per cycle.
- Update port: on every resolve (correct or not), upd_valid pulses 1 in cycle N+1 with upd_pc = ex_pc, upd_taken = taken, upd_target = target. upd_* hold their last value otherwise.
- Counters: on every resolve, br_cnt += 1; on a mispredict, mispred_cnt += 1 as well. Both update on the same edge and wrap modulo 2^COUNT_W.
- Back-to-back resolves in IDLE each produce an independent upd pulse and counter increment.
- Mispredict latency: 1 cycle to redirect_valid; total penalty = 1 + number of cycles redirect_ready is held low.

Test Plan:
- Reset, then BEQ with rs1=rs2=5, pc=0x100, imm=0x20, pred_taken=1, pred_target=0x120 -> no kill, no redirect; upd_valid pulse next cycle with taken=1, target=0x120; br_cnt=1, mispred_cnt=0.
- BLT with rs1=0xFFFFFFFF, rs2=1, pred_taken=0, pc=0x200, imm=0x40 -> kill_younger in cycle N; redirect_valid with pc 0x240 in N+1; mispred_cnt=1. Repeat as BLTU -> not taken, no mispredict.
- JALR with rs1=0x1003, imm=0, pred_taken=1, pred_target=0x1000 -> target 0x1002; redirect to 0x1002. Hold redirect_ready=0 for 3 cycles -> redirect_valid and redirect_pc stable; stall_ex high for 4 cycles; ex_valid pulses during the wait cause no counter change.
- BNE not-taken with pred_taken=1 at pc=0xFFFFFFFC -> redirect_pc=0x00000000 (wrap).
- Assert rst_n low while in WAIT_ACK -> redirect_valid=0 immediately and counters=0; the first resolve after release behaves as from IDLE.
- Preload br_cnt=2^COUNT_W-1 via 2^COUNT_W-1 resolves (COUNT_W=4) -> the next resolve wraps br_cnt to 0.
